// File: rtl/tri_arb_pkg.sv
// Shared types and helpers for the tri-state bus arbiter and its round-robin picker.
`default_nettype none

package tri_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    GRANT = 2'd2
  } arb_state_t;

  localparam int MAX_REQ = 16;

  // Index width with a floor of one bit so single-value counters stay legal.
  function automatic int ptr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick_k.sv
// Combinational round-robin picker: first asserted request strictly after ptr_i, with wrap.
`default_nettype none

module rr_pick_k
  import tri_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          valid_o,
  output logic [N-1:0]  onehot_o,
  output logic [PW-1:0] idx_o
);

  always_comb begin : p_pick
    logic [PW-1:0] cand;
    valid_o  = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    cand     = ptr_i;
    // The owner itself is the last candidate visited, giving it lowest priority.
    for (int k = 0; k < N; k++) begin
      cand = PW'(rr_next(int'(cand), N));
      if (!valid_o && req_i[cand]) begin
        valid_o        = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tri_bus_arbiter_k.sv
// Break-before-make round-robin arbiter driving active-low tri-state enables.
// Define TRI_ARB_PREEMPT_EN to force release after MAX_HOLD grant cycles when others wait.
`default_nettype none

module tri_bus_arbiter_k
  import tri_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         oe_,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       bus_busy
);

  localparam int PW = ptr_width(NUM_REQ);
  localparam int TW = ptr_width(TURN_CYCLES);
  localparam logic [TW-1:0] TURN_INIT = TW'(TURN_CYCLES - 1);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("tri_bus_arbiter_k: NUM_REQ must be 2..16");
  end
  if (TURN_CYCLES < 1) begin : g_bad_turn
    $error("tri_bus_arbiter_k: TURN_CYCLES must be >= 1");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("tri_bus_arbiter_k: MAX_HOLD must be >= 1");
  end

  arb_state_t           state_q, state_d;
  logic [TW-1:0]        turn_cnt_q, turn_cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   oe_q;
  logic [PW-1:0]        owner_q, owner_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 busy_q;
  logic                 release_w;

  logic                 pick_valid;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [PW-1:0]        pick_idx;

`ifdef TRI_ARB_PREEMPT_EN
  localparam int HW = ptr_width(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
`endif

  rr_pick_k #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    release_w  = !req[owner_q];
`ifdef TRI_ARB_PREEMPT_EN
    hold_cnt_d = hold_cnt_q;
    if (hold_cnt_q == HOLD_LAST && |(req & ~gnt_q)) begin
      release_w = 1'b1;
    end
`endif

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = TURN;
          turn_cnt_d = TURN_INIT;
        end
      end
      TURN: begin
        if (turn_cnt_q != '0) begin
          turn_cnt_d = turn_cnt_q - TW'(1);
        end else if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = pick_onehot;
          owner_d = pick_idx;
          ptr_d   = pick_idx;
`ifdef TRI_ARB_PREEMPT_EN
          hold_cnt_d = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (release_w) begin
          // Enables drop at this edge; the new owner waits out the turnaround.
          state_d    = TURN;
          gnt_d      = '0;
          turn_cnt_d = TURN_INIT;
        end
`ifdef TRI_ARB_PREEMPT_EN
        else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      turn_cnt_q <= '0;
      gnt_q      <= '0;
      oe_q       <= '1;
      owner_q    <= '0;
      ptr_q      <= PW'(NUM_REQ - 1);
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
      gnt_q      <= gnt_d;
      oe_q       <= ~gnt_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      busy_q     <= (state_d != IDLE);
    end
  end

`ifdef TRI_ARB_PREEMPT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`endif

  assign gnt      = gnt_q;
  assign oe_      = oe_q;
  assign owner    = owner_q;
  assign bus_busy = busy_q;

endmodule

`default_nettype wire
